// File: rtl/alu.sv
// RV32I execute-stage ALU: decodes opcode/funct3/funct7 and registers one result per cycle.
// Optional RV32M multiply (MUL/MULH/MULHSU/MULHU) is built when ALU_MUL_EN is defined.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [31:0] rd
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  logic        [31:0] w_result;
  logic        [31:0] r_rd;
  logic        [4:0]  w_shamt;
  logic signed [31:0] w_a_s;
  logic signed [31:0] w_b_s;
  logic        [31:0] w_sum;
  logic        [31:0] w_diff;
  logic        [31:0] w_sll;
  logic        [31:0] w_srl;
  logic        [31:0] w_sra;
  logic        [31:0] w_slt;
  logic        [31:0] w_sltu;

  assign w_shamt = rs2[4:0];
  assign w_a_s   = $signed(rs1);
  assign w_b_s   = $signed(rs2);
  assign w_sum   = rs1 + rs2;
  assign w_diff  = rs1 - rs2;
  assign w_sll   = rs1 << w_shamt;
  assign w_srl   = rs1 >> w_shamt;
  assign w_sra   = $unsigned(w_a_s >>> w_shamt);
  assign w_slt   = {31'd0, (w_a_s < w_b_s)};
  assign w_sltu  = {31'd0, (rs1 < rs2)};

  // funct3 map shared by OP (funct7 = 0) and OP-IMM; the shift direction is chosen by the caller
  function automatic logic [31:0] base_op(input logic [2:0]  f3,
                                          input logic [31:0] sum, input logic [31:0] sll,
                                          input logic [31:0] slt, input logic [31:0] sltu,
                                          input logic [31:0] a,   input logic [31:0] b,
                                          input logic [31:0] shr);
    case (f3)
      3'b000:  base_op = sum;
      3'b001:  base_op = sll;
      3'b010:  base_op = slt;
      3'b011:  base_op = sltu;
      3'b100:  base_op = a ^ b;
      3'b101:  base_op = shr;
      3'b110:  base_op = a | b;
      default: base_op = a & b;
    endcase
  endfunction

`ifdef ALU_MUL_EN
  logic signed [63:0] w_mul_ss;
  logic signed [65:0] w_mul_su;
  logic        [63:0] w_mul_uu;
  logic        [31:0] w_mul_res;

  assign w_mul_ss = 64'(w_a_s) * 64'(w_b_s);
  assign w_mul_su = $signed({{2{rs1[31]}}, rs1}) * $signed({2'b00, rs2});
  assign w_mul_uu = {32'd0, rs1} * {32'd0, rs2};

  always_comb begin
    w_mul_res = '0;
    case (funct3)
      3'b000:  w_mul_res = w_mul_uu[31:0];
      3'b001:  w_mul_res = w_mul_ss[63:32];
      3'b010:  w_mul_res = w_mul_su[63:32];
      3'b011:  w_mul_res = w_mul_uu[63:32];
      default: w_mul_res = '0;
    endcase
  end
`endif

  always_comb begin
    w_result = '0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          w_result = base_op(funct3, w_sum, w_sll, w_slt, w_sltu, rs1, rs2, w_srl);
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      w_result = w_diff;
          else if (funct3 == 3'b101) w_result = w_sra;
          else                       w_result = '0;
`ifdef ALU_MUL_EN
        end else if (funct7 == 7'b0000001) begin
          w_result = w_mul_res;
`endif
        end else begin
          w_result = '0;
        end
      end
      // OP-IMM has no SUBI; funct7[5] only matters for the right shift
      OPC_OPIMM: w_result = base_op(funct3, w_sum, w_sll, w_slt, w_sltu, rs1, rs2,
                                    funct7[5] ? w_sra : w_srl);
      OPC_LUI:   w_result = rs2;
      OPC_AUIPC: w_result = w_sum;
      default:   w_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rd <= '0;
    else     r_rd <= w_result;
  end

  assign rd = r_rd;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected results, a monitor pops one per posedge.
module tb_alu;

  logic        clk;
  logic        rst;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rd;

  int n_checks;
  int n_pass;
  logic [31:0] exp_q[$];
  string       name_q[$];

  alu dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endtask

  // Reference model: written from the instruction semantics using 64-bit arithmetic
  function automatic logic [31:0] model(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ua, ub;
    int sh;
    logic [63:0] wide;
    logic sra_sel;
    bit   is_op, is_imm;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sh = int'(b % 32);
    is_op  = (op == 7'h33);
    is_imm = (op == 7'h13);
    if (op == 7'h37) return b;
    if (op == 7'h17) return 32'(ua + ub);
    if (!is_op && !is_imm) return 32'd0;
    if (is_op && f7 == 7'h01) begin
`ifdef ALU_MUL_EN
      if (f3 == 3'd0) begin wide = 64'(ua * ub); return wide[31:0]; end
      if (f3 == 3'd1) begin wide = 64'(sa * sb); return wide[63:32]; end
      if (f3 == 3'd2) begin wide = 64'(sa * ub); return wide[63:32]; end
      if (f3 == 3'd3) begin wide = 64'(ua) * 64'(ub); return wide[63:32]; end
`endif
      return 32'd0;
    end
    if (is_op && f7 != 7'h00 && f7 != 7'h20) return 32'd0;
    if (is_op && f7 == 7'h20 && f3 != 3'd0 && f3 != 3'd5) return 32'd0;
    sra_sel = is_op ? (f7 == 7'h20) : f7[5];
    case (f3)
      3'd0: return (is_op && f7 == 7'h20) ? 32'(ua - ub) : 32'(ua + ub);
      3'd1: begin wide = 64'(ua) << sh; return wide[31:0]; end
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (ua < ub) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return sra_sel ? 32'(sa >>> sh) : 32'(ua >> sh);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic issue(input string nm, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    @(negedge clk);
    opcode = op; funct3 = f3; funct7 = f7; rs1 = a; rs2 = b;
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: one result per posedge while the scoreboard holds expectations
  always begin
    @(posedge clk);
    #1;
    if (!rst && exp_q.size() > 0) begin
      logic [31:0] e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check(nm, rd, e);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [31:0] a, b;
    int wait_cnt;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b0;
    rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678;
    opcode = 7'h37; funct3 = 3'd0; funct7 = 7'd0;
    #1 rst = 1'b1;
    #1 check("reset_async", rd, 32'd0);
    @(posedge clk); #1 check("reset_hold", rd, 32'd0);
    @(negedge clk); rst = 1'b0;

    issue("add",       7'h33, 3'd0, 7'h00, 32'd114514, 32'd1919810, 32'h001F0A94);
    issue("sub",       7'h33, 3'd0, 7'h20, 32'd114514, 32'd1919810, 32'hFFE47410);
    issue("sub_0_1",   7'h33, 3'd0, 7'h20, 32'd0, 32'd1, 32'hFFFFFFFF);
    issue("srl",       7'h33, 3'd5, 7'h00, 32'h80000000, 32'd4, 32'h08000000);
    issue("sra",       7'h33, 3'd5, 7'h20, 32'h80000000, 32'd4, 32'hF8000000);
    issue("sll_wrap",  7'h33, 3'd1, 7'h00, 32'h80000000, 32'h21, 32'h0);
    issue("slt_m1",    7'h33, 3'd2, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd1);
    issue("sltu_m1",   7'h33, 3'd3, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0);
    issue("slt_min",   7'h33, 3'd2, 7'h00, 32'h80000000, 32'h7FFFFFFF, 32'd1);
    issue("sltu_min",  7'h33, 3'd3, 7'h00, 32'h80000000, 32'h7FFFFFFF, 32'd0);
    issue("alt_bad",   7'h33, 3'd1, 7'h20, 32'h0000FFFF, 32'd3, 32'd0);
    issue("addi_f7",   7'h13, 3'd0, 7'h20, 32'd5, 32'd3, 32'd8);
    issue("srai",      7'h13, 3'd5, 7'h20, 32'h80000000, 32'd4, 32'hF8000000);
    issue("srli",      7'h13, 3'd5, 7'h00, 32'h80000000, 32'd4, 32'h08000000);
    issue("auipc",     7'h17, 3'd0, 7'h00, 32'h00001000, 32'hFFFFF000, 32'h0);
    issue("bad_opc",   7'h7F, 3'd0, 7'h00, 32'h1, 32'h2, 32'h0);
    issue("lui",       7'h37, 3'd0, 7'h00, 32'h0, 32'h12345000, 32'h12345000);
`ifdef ALU_MUL_EN
    issue("mul",       7'h33, 3'd0, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1);
    issue("mulh",      7'h33, 3'd1, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    issue("mulhsu",    7'h33, 3'd2, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue("mulhu",     7'h33, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
`else
    issue("mul",       7'h33, 3'd0, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    issue("mulh",      7'h33, 3'd1, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
    issue("mulhu",     7'h33, 3'd3, 7'h01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0);
`endif
    issue("div_zero",  7'h33, 3'd4, 7'h01, 32'd100, 32'd7, 32'h0);

    // Mid-stream reset: rd clears at once and stays clear while rst is high
    issue("pre_rst",   7'h37, 3'd0, 7'h00, 32'h0, 32'hCAFE0000, 32'hCAFE0000);
    @(negedge clk);
    rst = 1'b1;
    #1 check("mid_rst_async", rd, 32'd0);
    @(posedge clk); #1 check("mid_rst_hold", rd, 32'd0);
    @(negedge clk); rst = 1'b0;
    issue("post_rst",  7'h33, 3'd6, 7'h00, 32'hF0F00000, 32'h0000000F, 32'hF0F0000F);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1: op = 7'h33;
        2, 3: op = 7'h13;
        4:    op = ($urandom_range(0, 1) == 0) ? 7'h37 : 7'h17;
        default: op = 7'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0, 1: f7 = 7'h00;
        2:    f7 = 7'h20;
        3:    f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      a  = pick_val();
      b  = pick_val();
      issue("random", op, f3, f7, a, b, model(op, f3, f7, a, b));
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(negedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
